mult8_seq_ctrl: RTL and testbench
=================================

# mult8_seq_ctrl

Sequencing controller for the eight-lane 8×8 multiplier array and its operand router. It accepts one vector-multiply request per valid/ready handshake and drives the router's operand, `sew` and `count_0` inputs for one or two passes. It captures the eight 16-bit partial products and assembles them into per-element results (unsigned). It sits between the vector execute issue stage and the writeback mux.

## Interface

Parameters:
- none

Ports:
- `clk` in 1: clock; single clock domain, all state on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `in_valid_i` in 1: request valid.
- `in_ready_o` out 1: controller can accept a request.
- `a_i` in 64: operand A; `[31:0]` = word 1, `[63:32]` = word 2.
- `b_i` in 64: operand B; same layout as `a_i`.
- `sew_i` in 2: element width; `00`=8, `01`=16, `10`=32, `11` illegal.
- `out_valid_o` out 1: result valid.
- `out_ready_i` in 1: consumer accepts result.
- `result_o` out 64: assembled result.
- `err_o` out 1: illegal `sew` flag; qualified by `out_valid_o`.
- `mult_a1_o`, `mult_b1_o`, `mult_a2_o`, `mult_b2_o` out 32 each: router `data_in_A1/B1/A2/B2`; driven from the latched operand words.
- `mult_sew_o` out 2: router `sew`.
- `mult_count0_o` out 1: router `count_0`.
- `p1_i` … `p8_i` in 16 each: unsigned product of array lane k. The array is combinational and its outputs are valid in the same cycle.

## Operation

- Router lane mapping, with Ai/Bj = byte j of the latched word:
  - sew `00`: lane k = A_k·B_k for k = 0..7, using bytes of both words.
  - sew `01`: lanes 1-4 = A0B0, A1B1, A2B2, A3B3; lanes 5-8 = A0B1, A1B0, A2B3, A3B2.
  - sew `10`, pass c: lanes 1-4 = A0..A3·B(2c); lanes 5-8 = A0..A3·B(2c+1).
- FSM states: IDLE, PASS0, PASS1, DONE.
  - IDLE: `in_ready_o`=1. Handshake latches `a_i`, `b_i`, `sew_i` (and `mulh_i`), clears the accumulator, and moves to PASS0.
  - PASS0: `mult_count0_o`=0; products captured at the end of the cycle. Next state is PASS1 if sew=`10`, otherwise DONE.
  - PASS1: `mult_count0_o`=1; products captured; next state DONE.
  - DONE: `out_valid_o`=1. Holds `result_o` and `err_o` stable until `out_ready_i`, then goes to IDLE.
- Accumulation uses a 64-bit accumulator.
  - sew `10`: each pass adds Σ (Ai·Bj) << 8(i+j), which yields the full 64-bit product.
  - sew `01`: element 0 = p1 + (p5+p6)<<8 + p2<<16; element 1 = p3 + (p7+p8)<<8 + p4<<16 (32-bit each).
- Result packing (low half):
  - sew `00`: byte k = p_k[7:0].
  - sew `01`: `[15:0]`=elem0[15:0], `[31:16]`=elem1[15:0], `[63:32]`=0.
  - sew `10`: `[31:0]`=product[31:0], upper bits 0.
- Illegal sew `11`:
  - Accepted; one pass with `mult_sew_o`=`11`, and the products are ignored.
  - `result_o`=0, `err_o`=1.

## Timing

- Reset values:
  - state IDLE, `in_ready_o`=1, `out_valid_o`=0.
  - `result_o`=0, `err_o`=0, accumulator=0.
  - all `mult_*` outputs 0, `mult_count0_o`=0.
- Latency from the accept edge N:
  - `out_valid_o` rises after edge N+1 for sew `00`/`01`/`11`.
  - `out_valid_o` rises after edge N+2 for sew `10`.
- Throughput:
  - `in_ready_o` is low from PASS0 through DONE, so there is no overlap between requests.
  - The minimum spacing between accepts is 3 cycles (sew `10`: 4).
- Back-pressure: `out_valid_o` stays high and the result is frozen for an arbitrary `out_ready_i`-low stall. `in_valid_i` is ignored during the stall.
- Reset asserted mid-operation: the request is discarded immediately and the FSM returns to IDLE. No `out_valid_o` is produced for the discarded request.
- Changes on `a_i`/`b_i`/`sew_i` after the accept edge have no effect.

## Configuration

- `MULT8_SEQ_HIGH_EN` defined:
  - Adds input port `mulh_i` (1 bit), latched with the request.
  - When the latched bit is 1, the high half is packed instead: sew `00` byte k = p_k[15:8]; sew `01` halves = elem[31:16]; sew `10` `[31:0]` = product[63:32].
- `MULT8_SEQ_HIGH_EN` undefined: no `mulh_i` port; the low half is always packed.

## Test plan

- Reset during PASS1 of a sew `10` request -> `out_valid_o` never rises for it; `in_ready_o`=1 after reset; the next sew `00` request returns the correct result.
- sew `00`, a=0x0807060504030201, b=0x1010101010101010 -> `result_o`=0x8070605040302010 one cycle after accept.
- sew `00`, same a, b bytes all 0x20 -> low result 0x00E0C0A080604020; with `MULT8_SEQ_HIGH_EN` and `mulh_i`=1 the result is 0x0100000000000000.
- sew `01`, a=0x00030100, b=0x00020100 -> low result 0x0000000000060000; high result (macro on) 0x0000000000000001.
- sew `10`, a=0xFFFFFFFF, b=0x00000002:
  - `mult_count0_o` reads 0 then 1 on consecutive cycles.
  - low result 0x00000000FFFFFFFE after 2 cycles; high result 0x0000000000000001.
- sew `11` with `out_ready_i` held low 5 cycles -> `err_o`=1, `result_o`=0, held stable; `in_ready_o` stays 0 until the handshake.

Source files
------------

// File: rtl/mult8_seq_ctrl_if.sv
// rtl/mult8_seq_ctrl_if.sv - request, response and router bundle for mult8_seq_ctrl
//
// Groups the issue-side request handshake, the writeback-side response
// handshake and the multiplier router/array signals. Suffixes are relative to
// the controller: modport slave is the controller view, modport master is the
// view of the surrounding issue, writeback and multiplier-array logic.
//
// Configuration macro: MULT8_SEQ_HIGH_EN adds the mulh_i request bit.
interface mult8_seq_ctrl_if;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [63:0] a_i;
    logic [63:0] b_i;
    logic [1:0]  sew_i;
`ifdef MULT8_SEQ_HIGH_EN
    logic        mulh_i;
`endif
    logic        out_valid_o;
    logic        out_ready_i;
    logic [63:0] result_o;
    logic        err_o;
    logic [31:0] mult_a1_o;
    logic [31:0] mult_b1_o;
    logic [31:0] mult_a2_o;
    logic [31:0] mult_b2_o;
    logic [1:0]  mult_sew_o;
    logic        mult_count0_o;
    logic [15:0] p1_i;
    logic [15:0] p2_i;
    logic [15:0] p3_i;
    logic [15:0] p4_i;
    logic [15:0] p5_i;
    logic [15:0] p6_i;
    logic [15:0] p7_i;
    logic [15:0] p8_i;

    modport slave (
        input  in_valid_i, a_i, b_i, sew_i,
`ifdef MULT8_SEQ_HIGH_EN
        input  mulh_i,
`endif
        input  out_ready_i,
        input  p1_i, p2_i, p3_i, p4_i, p5_i, p6_i, p7_i, p8_i,
        output in_ready_o, out_valid_o, result_o, err_o,
        output mult_a1_o, mult_b1_o, mult_a2_o, mult_b2_o,
        output mult_sew_o, mult_count0_o
    );

    modport master (
        output in_valid_i, a_i, b_i, sew_i,
`ifdef MULT8_SEQ_HIGH_EN
        output mulh_i,
`endif
        output out_ready_i,
        output p1_i, p2_i, p3_i, p4_i, p5_i, p6_i, p7_i, p8_i,
        input  in_ready_o, out_valid_o, result_o, err_o,
        input  mult_a1_o, mult_b1_o, mult_a2_o, mult_b2_o,
        input  mult_sew_o, mult_count0_o
    );
endinterface

// File: rtl/mult8_seq_ctrl.sv
// rtl/mult8_seq_ctrl.sv - sequencing controller for the eight-lane 8x8 multiplier array
//
// Accepts one vector multiply per in_valid_i/in_ready_o handshake, drives the
// operand router for one pass (sew 8/16 and illegal sew) or two passes
// (sew 32), captures the eight unsigned lane products and holds the packed
// result on result_o until out_ready_i.
//
// Ports:
//   clk   - clock, all state on the rising edge
//   reset - asynchronous active-high reset
//   bus   - mult8_seq_ctrl_if.slave:
//             request   in_valid_i/in_ready_o, a_i, b_i, sew_i (+ mulh_i)
//             response  out_valid_o/out_ready_i, result_o, err_o
//             router    mult_a1_o, mult_b1_o, mult_a2_o, mult_b2_o,
//                       mult_sew_o, mult_count0_o
//             array     p1_i .. p8_i (combinational lane products)
//
// Configuration macro: MULT8_SEQ_HIGH_EN - adds mulh_i; when the latched bit
// is set the upper half of each element product is packed instead.
module mult8_seq_ctrl (
    input  logic            clk,
    input  logic            reset,
    mult8_seq_ctrl_if.slave bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PASS0 = 2'd1;
    localparam logic [1:0] ST_PASS1 = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [1:0] SEW_8   = 2'b00;
    localparam logic [1:0] SEW_16  = 2'b01;
    localparam logic [1:0] SEW_32  = 2'b10;
    localparam logic [1:0] SEW_BAD = 2'b11;

    logic [1:0]  state_q, state_d;
    logic [63:0] a_q, a_d;
    logic [63:0] b_q, b_d;
    logic [1:0]  sew_q, sew_d;
    logic [63:0] acc_q, acc_d;
    logic        mulh_q;

    logic [15:0] p [8];
    logic [63:0] row_lo;
    logic [63:0] row_hi;
    logic [63:0] pass_sum;
    logic [31:0] elem0;
    logic [31:0] elem1;
    logic [63:0] byte_pack;
    logic [63:0] result;

    assign p[0] = bus.p1_i;
    assign p[1] = bus.p2_i;
    assign p[2] = bus.p3_i;
    assign p[3] = bus.p4_i;
    assign p[4] = bus.p5_i;
    assign p[5] = bus.p6_i;
    assign p[6] = bus.p7_i;
    assign p[7] = bus.p8_i;

`ifdef MULT8_SEQ_HIGH_EN
    logic mulh_d;

    always_comb begin
        mulh_d = mulh_q;
        if (state_q == ST_IDLE && bus.in_valid_i) begin
            mulh_d = bus.mulh_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mulh_q <= 1'b0;
        end else begin
            mulh_q <= mulh_d;
        end
    end
`else
    assign mulh_q = 1'b0;
`endif

    // Lane combining. For sew 32 each pass multiplies all of A by two bytes
    // of B: lanes 1-4 carry B(2c), lanes 5-8 carry B(2c+1), so the second
    // row sits one byte higher and pass 1 sits two bytes above pass 0.
    // For sew 16 lanes 5-8 are the cross terms of each 16x16 element.
    always_comb begin
        row_lo   = 64'(p[0]) + (64'(p[1]) << 8) + (64'(p[2]) << 16) + (64'(p[3]) << 24);
        row_hi   = 64'(p[4]) + (64'(p[5]) << 8) + (64'(p[6]) << 16) + (64'(p[7]) << 24);
        pass_sum = row_lo + (row_hi << 8);
        if (state_q == ST_PASS1) begin
            pass_sum = pass_sum << 16;
        end
        elem0 = 32'(p[0]) + ((32'(p[4]) + 32'(p[5])) << 8) + (32'(p[1]) << 16);
        elem1 = 32'(p[2]) + ((32'(p[6]) + 32'(p[7])) << 8) + (32'(p[3]) << 16);
        // sew 8 elements are packed at capture time: 128 bits of raw
        // products would not fit the 64-bit accumulator.
        byte_pack = '0;
        for (int k = 0; k < 8; k++) begin
            byte_pack[8*k +: 8] = mulh_q ? p[k][15:8] : p[k][7:0];
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sew_d   = sew_q;
        acc_d   = acc_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid_i) begin
                    a_d     = bus.a_i;
                    b_d     = bus.b_i;
                    sew_d   = bus.sew_i;
                    acc_d   = '0;
                    state_d = ST_PASS0;
                end
            end
            ST_PASS0: begin
                case (sew_q)
                    SEW_8:   acc_d = byte_pack;
                    SEW_16:  acc_d = {elem1, elem0};
                    SEW_32:  acc_d = acc_q + pass_sum;
                    default: acc_d = acc_q;
                endcase
                state_d = (sew_q == SEW_32) ? ST_PASS1 : ST_DONE;
            end
            ST_PASS1: begin
                acc_d   = acc_q + pass_sum;
                state_d = ST_DONE;
            end
            default: begin
                if (bus.out_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sew_q   <= SEW_8;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sew_q   <= sew_d;
            acc_q   <= acc_d;
        end
    end

    // The accumulator holds {elem1, elem0} for sew 16 and the full 64-bit
    // product for sew 32; only the selected half of each is returned.
    always_comb begin
        result = '0;
        case (sew_q)
            SEW_8:   result = acc_q;
            SEW_16:  result[31:0] = mulh_q ? {acc_q[63:48], acc_q[31:16]}
                                           : {acc_q[47:32], acc_q[15:0]};
            SEW_32:  result[31:0] = mulh_q ? acc_q[63:32] : acc_q[31:0];
            default: result = '0;
        endcase
    end

    assign bus.in_ready_o    = (state_q == ST_IDLE);
    assign bus.out_valid_o   = (state_q == ST_DONE);
    assign bus.result_o      = result;
    assign bus.err_o         = (state_q == ST_DONE) && (sew_q == SEW_BAD);
    assign bus.mult_a1_o     = a_q[31:0];
    assign bus.mult_a2_o     = a_q[63:32];
    assign bus.mult_b1_o     = b_q[31:0];
    assign bus.mult_b2_o     = b_q[63:32];
    assign bus.mult_sew_o    = sew_q;
    assign bus.mult_count0_o = (state_q == ST_PASS1);

endmodule

// File: tb/tb_mult8_seq_ctrl.sv
// tb/tb_mult8_seq_ctrl.sv - scoreboard testbench for mult8_seq_ctrl
module tb_mult8_seq_ctrl;

    logic clk = 1'b0;
    logic reset;
    int   checks  = 0;
    int   errors  = 0;
    int   issued  = 0;
    int   outputs = 0;

    logic [64:0] sb_q [$];

    mult8_seq_ctrl_if bus ();

    mult8_seq_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Router and multiplier array environment
    logic [15:0] prod [8];
    logic [63:0] rt_a;
    logic [63:0] rt_b;
    int          rt_c;

    function automatic logic [15:0] bmul(input logic [63:0] x, input logic [63:0] y,
                                         input int i, input int j);
        return 16'(x[8*i +: 8]) * 16'(y[8*j +: 8]);
    endfunction

    always_comb begin
        rt_a = {bus.mult_a2_o, bus.mult_a1_o};
        rt_b = {bus.mult_b2_o, bus.mult_b1_o};
        rt_c = bus.mult_count0_o ? 1 : 0;
        for (int k = 0; k < 8; k++) prod[k] = '0;
        case (bus.mult_sew_o)
            2'b00: for (int k = 0; k < 8; k++) prod[k] = bmul(rt_a, rt_b, k, k);
            2'b01: begin
                for (int k = 0; k < 4; k++) prod[k] = bmul(rt_a, rt_b, k, k);
                prod[4] = bmul(rt_a, rt_b, 0, 1);
                prod[5] = bmul(rt_a, rt_b, 1, 0);
                prod[6] = bmul(rt_a, rt_b, 2, 3);
                prod[7] = bmul(rt_a, rt_b, 3, 2);
            end
            2'b10: for (int i = 0; i < 4; i++) begin
                prod[i]     = bmul(rt_a, rt_b, i, 2 * rt_c);
                prod[4 + i] = bmul(rt_a, rt_b, i, 2 * rt_c + 1);
            end
            default: for (int k = 0; k < 8; k++) prod[k] = bmul(rt_a, rt_b, k, k) ^ 16'hA5A5;
        endcase
    end

    assign bus.p1_i = prod[0];
    assign bus.p2_i = prod[1];
    assign bus.p3_i = prod[2];
    assign bus.p4_i = prod[3];
    assign bus.p5_i = prod[4];
    assign bus.p6_i = prod[5];
    assign bus.p7_i = prod[6];
    assign bus.p8_i = prod[7];

    // Reference: whole-element unsigned multiplies, {err, result}
    function automatic logic [64:0] ref_model(input logic [63:0] a, input logic [63:0] b,
                                              input logic [1:0] sew, input logic hi);
        logic [63:0] r;
        logic [15:0] p16;
        logic [31:0] p32;
        logic [63:0] p64;
        r = '0;
        case (sew)
            2'b00: for (int k = 0; k < 8; k++) begin
                p16 = 16'(a[8*k +: 8]) * 16'(b[8*k +: 8]);
                r[8*k +: 8] = hi ? p16[15:8] : p16[7:0];
            end
            2'b01: for (int e = 0; e < 2; e++) begin
                p32 = 32'(a[16*e +: 16]) * 32'(b[16*e +: 16]);
                r[16*e +: 16] = hi ? p32[31:16] : p32[15:0];
            end
            2'b10: begin
                p64 = 64'(a[31:0]) * 64'(b[31:0]);
                r[31:0] = hi ? p64[63:32] : p64[31:0];
            end
            default: return {1'b1, 64'd0};
        endcase
        return {1'b0, r};
    endfunction

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // Monitor: every presented result is compared against the oldest
    // outstanding expectation; it is retired on the handshake.
    logic [64:0] popped;
    always @(negedge clk) begin
        if (!reset && bus.out_valid_o) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got result 0x%0h with nothing pending, expected no out_valid_o",
                         bus.result_o);
            end else begin
                chk64("result", bus.result_o, sb_q[0][63:0]);
                chk1("err", bus.err_o, sb_q[0][64]);
                if (bus.out_ready_i) begin
                    popped = sb_q.pop_front();
                    outputs++;
                end
            end
        end
    end

    // Issue one request from posedge+1; returns at posedge+1 after the
    // response handshake.
    task automatic do_req(input logic [63:0] a, input logic [63:0] b, input logic [1:0] sew,
                          input logic [64:0] exp, input int stall);
        int budget;
        int lat;
        bus.a_i        = a;
        bus.b_i        = b;
        bus.sew_i      = sew;
        bus.in_valid_i = 1'b1;
        budget = 0;
        @(negedge clk);
        while (!bus.in_ready_o && budget < 20) begin
            budget++;
            @(negedge clk);
        end
        if (!bus.in_ready_o) begin
            chk1("accept_timeout", bus.in_ready_o, 1'b1);
            bus.in_valid_i = 1'b0;
            return;
        end
        sb_q.push_back(exp);
        issued++;
        @(posedge clk);
        #1;
        bus.in_valid_i = 1'b0;
        bus.a_i        = {$urandom, $urandom};
        bus.b_i        = {$urandom, $urandom};
        bus.sew_i      = 2'($urandom_range(0, 3));
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                chk1("busy_in_ready", bus.in_ready_o, 1'b0);
                chk1("pass0_count0", bus.mult_count0_o, 1'b0);
                chk64("router_sew", 64'(bus.mult_sew_o), 64'(sew));
            end
            if (lat == 2 && sew == 2'b10) begin
                chk1("pass1_count0", bus.mult_count0_o, 1'b1);
            end
        end while (!bus.out_valid_o && lat < 10);
        chk64("latency", 64'(lat), (sew == 2'b10) ? 64'd3 : 64'd2);
        for (int s = 0; s < stall; s++) begin
            @(posedge clk);
            #1;
            bus.in_valid_i = 1'b1;
            bus.a_i        = {$urandom, $urandom};
            @(negedge clk);
            chk1("stall_in_ready", bus.in_ready_o, 1'b0);
            chk1("stall_out_valid", bus.out_valid_o, 1'b1);
        end
        @(posedge clk);
        #1;
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "time limit");
    end

    initial begin
        logic [63:0] ra;
        logic [63:0] rb;
        logic [1:0]  rs;
        logic        rh;

        reset           = 1'b1;
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b0;
        bus.a_i         = '0;
        bus.b_i         = '0;
        bus.sew_i       = '0;
`ifdef MULT8_SEQ_HIGH_EN
        bus.mulh_i      = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk1("rst_in_ready", bus.in_ready_o, 1'b1);
        chk1("rst_out_valid", bus.out_valid_o, 1'b0);
        chk64("rst_result", bus.result_o, 64'd0);
        chk1("rst_err", bus.err_o, 1'b0);
        chk64("rst_mult_a", {bus.mult_a2_o, bus.mult_a1_o}, 64'd0);
        chk64("rst_mult_b", {bus.mult_b2_o, bus.mult_b1_o}, 64'd0);
        chk64("rst_mult_sew", 64'(bus.mult_sew_o), 64'd0);
        chk1("rst_count0", bus.mult_count0_o, 1'b0);
        reset = 1'b0;

        do_req(64'h0807060504030201, 64'h1010101010101010, 2'b00, {1'b0, 64'h8070605040302010}, 0);
        do_req(64'h0807060504030201, 64'h2020202020202020, 2'b00, {1'b0, 64'h00E0C0A080604020}, 1);
        do_req(64'h0000000000030100, 64'h0000000000020100, 2'b01, {1'b0, 64'h0000000000060000}, 0);
        do_req(64'h00000000FFFFFFFF, 64'h0000000000000002, 2'b10, {1'b0, 64'h00000000FFFFFFFE}, 2);
`ifdef MULT8_SEQ_HIGH_EN
        bus.mulh_i = 1'b1;
        do_req(64'h0807060504030201, 64'h2020202020202020, 2'b00, {1'b0, 64'h0100000000000000}, 0);
        do_req(64'h0000000000030100, 64'h0000000000020100, 2'b01, {1'b0, 64'h0000000000000001}, 0);
        do_req(64'h00000000FFFFFFFF, 64'h0000000000000002, 2'b10, {1'b0, 64'h0000000000000001}, 0);
        bus.mulh_i = 1'b0;
`endif
        do_req(64'h1234567890ABCDEF, 64'hFEDCBA0987654321, 2'b11, {1'b1, 64'd0}, 5);

        // Reset during PASS1 of a sew 32 request: the request must vanish
        bus.a_i        = 64'h00000000DEADBEEF;
        bus.b_i        = 64'h0000000012345678;
        bus.sew_i      = 2'b10;
        bus.in_valid_i = 1'b1;
        @(negedge clk);
        chk1("abort_accept_ready", bus.in_ready_o, 1'b1);
        @(posedge clk);
        #1;
        bus.in_valid_i = 1'b0;
        @(posedge clk);
        #1;
        chk1("abort_in_pass1", bus.mult_count0_o, 1'b1);
        reset = 1'b1;
        #1;
        chk1("abort_in_ready", bus.in_ready_o, 1'b1);
        chk1("abort_out_valid", bus.out_valid_o, 1'b0);
        chk64("abort_result", bus.result_o, 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk1("abort_no_valid", bus.out_valid_o, 1'b0);
        end
        @(posedge clk);
        #1;
        do_req(64'h0807060504030201, 64'h1010101010101010, 2'b00, {1'b0, 64'h8070605040302010}, 0);

        // Boundary operands
        for (int s = 0; s < 3; s++) begin
            rs = 2'(s);
            do_req('1, '1, rs, ref_model('1, '1, rs, 1'b0), 0);
        end

        for (int n = 0; n < 40; n++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            rs = 2'($urandom_range(0, 3));
            rh = 1'b0;
`ifdef MULT8_SEQ_HIGH_EN
            rh = 1'($urandom_range(0, 1));
            bus.mulh_i = rh;
`endif
            do_req(ra, rb, rs, ref_model(ra, rb, rs, rh), int'($urandom_range(0, 3)));
        end

        repeat (3) @(negedge clk);
        chk64("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        chk64("outputs_drained", 64'(outputs), 64'(issued));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
